// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_pkg
// Description : Opcode constants and FSM state encoding shared by the ALU.
// Revision    : 1.0 - initial release
//==============================================================================
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
//==============================================================================
// Module      : alu_mul_seq
// Description : Iterative shift-add multiplier, one partial product per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == c_cnt_last);

    // The final iteration's sum is presented directly so the consumer can
    // capture it on the same edge that completes the last step.
    assign done    = r_busy && w_last;
    assign product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
//==============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshake and iterative MUL.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;

    logic             w_fire;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == HOLD);
    assign result      = r_result;
    assign zero        = r_zero;
    assign overflow    = r_overflow;

    assign w_fire      = in_valid && in_ready;
    assign w_mul_start = w_fire && (operation == OP_MUL);
    assign w_sum       = a + b;
    assign w_diff      = a - b;
    assign w_shamt     = b[SH_W-1:0];

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    // SLT uses a true signed compare, so it stays correct when a-b overflows.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (operation)
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: w_alu_res = a << w_shamt;
            OP_SRL: w_alu_res = a >> w_shamt;
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_state_next = (operation == OP_MUL) ? MUL : HOLD;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_fire && (operation != OP_MUL)) begin
            r_result   <= w_alu_res;
            r_zero     <= (w_alu_res == '0);
            r_overflow <= w_alu_ovf;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_result   <= w_mul_prod;
            r_zero     <= (w_mul_prod == '0);
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_mc
// Description : Directed scoreboard bench for alu_mc (WIDTH=32).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_mc;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             o;
        int               lat;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       operation = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    exp_t sb[$];
    exp_t cur;
    bit   seen = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: first cycle of out_valid pops and checks, later cycles check stability.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got result %h with no pending operation", result);
                    cur = '{result, zero, overflow, 0, 0};
                end else begin
                    cur = sb.pop_front();
                    chk("result",   64'(result),   64'(cur.r));
                    chk("zero",     64'(zero),     64'(cur.z));
                    chk("overflow", 64'(overflow), 64'(cur.o));
                    chk("latency",  64'(cyc - cur.acc + 1), 64'(cur.lat));
                end
            end else begin
                chk("hold_result", 64'({result, zero, overflow}), 64'({cur.r, cur.z, cur.o}));
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [WIDTH-1:0] er, input logic ez, input logic eo, input int lat);
        int k;
        in_valid  = 1'b1;
        operation = op;
        a         = ia;
        b         = ib;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op %b", op);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{er, ez, eo, lat, cyc + 1});
        @(negedge clk);
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        operation = 3'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results pending, in_ready %b", sb.size(), in_ready);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_zero",      64'(zero),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(3'b000, 32'h0000FFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
        issue(3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1);
        issue(3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1);
        issue(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1);
        issue(3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
        issue(3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
        issue(3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
        issue(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1);
        issue(3'b100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1);
        issue(3'b100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1);
        issue(3'b101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1);
        issue(3'b011, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33);
        issue(3'b011, 32'h0000FFFF, 32'h00000003, 32'h0002FFFD, 1'b0, 1'b0, 33);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33);
        drain();

        // Backpressure: new operands offered while the result is held.
        out_ready = 1'b0;
        issue(3'b010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1);
        in_valid  = 1'b1;
        operation = 3'b001;
        a         = 32'hDEADBEEF;
        b         = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_result",   64'(result),   64'h3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_after_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset in the middle of a multiply discards it.
        issue(3'b011, 32'h00001234, 32'h00005678, 32'h06260060, 1'b0, 1'b0, 33);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result",    64'(result),    64'd0);
        chk("midrst_zero",      64'(zero),      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        issue(3'b010, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, multiplier cycle-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 operation  input  3  opcode, see REQ-013.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH; zero  output  1 (result==0); overflow  output  1 (signed add/sub overflow).

Function
REQ-013 Opcodes: 000 AND, 001 OR, 010 ADD, 011 MUL (low WIDTH bits of product), 100 SLL (a << b[log2 WIDTH-1:0]), 101 SRL (logical, same shift field), 110 SUB (a-b), 111 SLT (signed a<b -> 1 else 0); no opcode is illegal.
REQ-014 FSM states IDLE, MUL, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 Transfer in: in_valid & in_ready on a rising edge; a, b, operation are captured at that edge only.
REQ-016 IDLE + transfer of non-MUL op -> HOLD; result, zero, overflow loaded at same edge; out_valid=1 on the next cycle (latency 1).
REQ-017 IDLE + transfer of MUL -> MUL; multiplicand=a, multiplier=b, accumulator=0, counter=0.
REQ-018 MUL: each cycle, if multiplier[0] then accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter++; after WIDTH iterations -> HOLD with result=accumulator; out_valid first high WIDTH+1 cycles after acceptance edge.
REQ-019 HOLD: out_valid=1; result/zero/overflow stable while out_ready=0; out_valid & out_ready -> IDLE next edge.
REQ-020 No early termination of MUL on zero operands; latency fixed at WIDTH+1.
REQ-021 overflow SHALL be 1 only for ADD/SUB when operand signs and result sign indicate signed overflow; 0 for all other ops.
REQ-022 SLT SHALL compare signed operands directly, correct even when a-b overflows.
REQ-023 in_valid while not IDLE is ignored; operands change during MUL/HOLD do not affect the result.
REQ-024 zero SHALL equal (result==0) for every op, including MUL and SLT.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, out_valid=0, result=0, zero=0, overflow=0, counter=0, in_ready=1 after deassertion.
REQ-026 Reset mid-MUL or mid-HOLD SHALL discard the operation; no out_valid pulse follows.
REQ-027 rst_n deassertion SHALL be treated as synchronous to clk by the surrounding design; no internal synchronizer.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode constants (OP_AND..OP_SLT) and the FSM state encoding type.
REQ-029 Iterative multiplier SHALL be a sub-module alu_mul_seq (start, a, b, done, product), WIDTH-parametrised; the top holds the FSM, combinational single-cycle ops and output registers.

Verification (WIDTH=32)
REQ-030 AND a=0000FFFF b=00000001 -> one cycle after acceptance out_valid=1, result=00000001, zero=0, overflow=0.
REQ-031 SUB a=00000005 b=00000005 -> result=00000000, zero=1; ADD a=7FFFFFFF b=00000001 -> result=80000000, overflow=1.
REQ-032 SLT a=80000000 b=00000001 -> result=00000001; SLL a=00000001 b=0000001F -> 80000000; SRL a=80000000 b=00000004 -> 08000000.
REQ-033 MUL a=00010000 b=00010000 -> out_valid exactly 33 cycles after acceptance, result=00000000, zero=1; MUL 0000FFFF*00000003 -> 0002FFFD.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in HOLD with in_valid=1 and new operands -> in_ready=0, result unchanged; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 at MUL cycle 10 -> out_valid=0, result=0 immediately; after release, ADD 3+4 -> 00000007 with normal latency.
